pc_ctrl_seq: RTL and testbench

Sequential program-counter unit for the fetch stage: holds the architectural PC register, advances it by the instruction size, resolves conditional and register branches against the {Z,V,N} flag register, and redirects fetch with a one-cycle flush pulse. It generalises combinational next-PC selection with parameterised width and immediate size, stall hold, a HALT state, and saturating branch statistics counters. It sits between decode (branch resolution, halt detect) and instruction memory (PC drive).

---
 rtl/pc_ctrl_seq_if.sv | 34 +++
 rtl/pc_ctrl_seq.sv | 142 ++++++++++++++
 tb/tb_pc_ctrl_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_seq_if.sv
// Fetch-stage program-counter interface.
// Decode resolves branches and detects HALT (master side).
// The PC unit returns the fetch PC, redirect flush, halt status and statistics (slave side).
interface pc_ctrl_seq_if #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 9,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             halt;
    logic             br_valid;
    logic             br_reg;
    logic [2:0]       cond;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] br_pc;
    logic [2:0]       flags;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output stall, halt, br_valid, br_reg, cond, imm, rs_data, br_pc, flags,
        input  pc, pc_plus, flush, halted, br_count, taken_count
    );

    modport slave (
        input  stall, halt, br_valid, br_reg, cond, imm, rs_data, br_pc, flags,
        output pc, pc_plus, flush, halted, br_count, taken_count
    );
endinterface

// File: rtl/pc_ctrl_seq.sv
// Sequential program-counter unit for the fetch stage.
// Holds the architectural PC and advances it by INC each cycle.
// Resolves B/BR branches against the {Z,V,N} flags and redirects fetch with a one-cycle flush.
// Supports stall hold and a terminal HALTED state that only reset leaves.
// Keeps saturating counters of resolved and taken branches.
module pc_ctrl_seq #(
    parameter int               WIDTH    = 16,
    parameter int               IMM_W    = 9,
    parameter int               INC      = 2,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
    parameter int               CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    pc_ctrl_seq_if.slave bus
);
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] pc_plus_s;
    logic [WIDTH-1:0] imm_ext_s;
    logic [WIDTH-1:0] target_s;
    logic             flush_r;
    logic             flush_next_s;
    logic             halted_r;
    logic [CNT_W-1:0] br_count_r;
    logic [CNT_W-1:0] br_count_next_s;
    logic [CNT_W-1:0] taken_count_r;
    logic [CNT_W-1:0] taken_count_next_s;
    logic             z_s;
    logic             v_s;
    logic             n_s;
    logic             cond_ok_s;
    logic             taken_s;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    assign z_s       = bus.flags[2];
    assign v_s       = bus.flags[1];
    assign n_s       = bus.flags[0];
    assign pc_plus_s = pc_r + WIDTH'(INC);
    assign imm_ext_s = WIDTH'($signed(bus.imm));
    // The immediate counts halfwords; BR targets pass bit 0 through untouched
    assign target_s  = bus.br_reg ? bus.rs_data
                                  : (bus.br_pc + WIDTH'(INC) + {imm_ext_s[WIDTH-2:0], 1'b0});

    // Evaluate the branch condition code against the flags
    always_comb begin
        cond_ok_s = 1'b0;
        case (bus.cond)
            3'b000:  cond_ok_s = ~z_s;
            3'b001:  cond_ok_s = z_s;
            3'b010:  cond_ok_s = ~z_s & ~n_s;
            3'b011:  cond_ok_s = n_s;
            3'b100:  cond_ok_s = z_s | (~z_s & ~n_s);
            3'b101:  cond_ok_s = n_s | z_s;
            3'b110:  cond_ok_s = v_s;
            3'b111:  cond_ok_s = 1'b1;
            default: cond_ok_s = 1'b0;
        endcase
    end

    assign taken_s = (state_r == ST_RUN) & bus.br_valid & cond_ok_s;

    // Next state, next PC, flush and counter updates
    always_comb begin
        state_next_s       = state_r;
        pc_next_s          = pc_r;
        flush_next_s       = 1'b0;
        br_count_next_s    = br_count_r;
        taken_count_next_s = taken_count_r;
        case (state_r)
            ST_RUN: begin
                if (bus.br_valid) begin
                    br_count_next_s = sat_inc(br_count_r);
                end else begin
                    br_count_next_s = br_count_r;
                end
                // A taken branch beats both stall and halt
                if (taken_s) begin
                    pc_next_s          = target_s;
                    flush_next_s       = 1'b1;
                    taken_count_next_s = sat_inc(taken_count_r);
                end else if (bus.stall) begin
                    pc_next_s = pc_r;
                end else if (bus.halt) begin
                    pc_next_s    = pc_r;
                    state_next_s = ST_HALTED;
                end else begin
                    pc_next_s = pc_plus_s;
                end
            end
            ST_HALTED: begin
                state_next_s = ST_HALTED;
            end
            default: begin
                state_next_s = ST_HALTED;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            flush_r       <= 1'b0;
            halted_r      <= 1'b0;
            br_count_r    <= {CNT_W{1'b0}};
            taken_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            flush_r       <= flush_next_s;
            halted_r      <= (state_next_s == ST_HALTED);
            br_count_r    <= br_count_next_s;
            taken_count_r <= taken_count_next_s;
        end
    end

    assign bus.pc          = pc_r;
    assign bus.pc_plus     = pc_plus_s;
    assign bus.flush       = flush_r;
    assign bus.halted      = halted_r;
    assign bus.br_count    = br_count_r;
    assign bus.taken_count = taken_count_r;
endmodule

// File: tb/tb_pc_ctrl_seq.sv
// Testbench for pc_ctrl_seq: directed steps from the test plan followed by random traffic.
// Every cycle is checked against a behavioural model built from the architectural rules.
module tb_pc_ctrl_seq;
    localparam int WIDTH = 16;
    localparam int IMM_W = 9;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int m_pc, m_flush, m_halted, m_brc, m_tkc;

    pc_ctrl_seq_if #(.WIDTH(WIDTH), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();

    pc_ctrl_seq #(.WIDTH(WIDTH), .IMM_W(IMM_W), .INC(2), .RESET_PC(16'h0000), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic bit cond_true(input int c, input bit z, input bit v, input bit n);
        case (c)
            0:       return !z;
            1:       return z;
            2:       return !z && !n;
            3:       return n;
            4:       return z || !n;
            5:       return n || z;
            6:       return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model on the inputs currently applied
    task automatic model_step();
        int simm, tgt;
        bit tk;
        if (rst) begin
            m_pc = 0; m_flush = 0; m_halted = 0; m_brc = 0; m_tkc = 0;
        end else if (m_halted == 0) begin
            tk = bus.br_valid && cond_true(int'(bus.cond), bus.flags[2], bus.flags[1], bus.flags[0]);
            simm = (int'(bus.imm) >= 256) ? int'(bus.imm) - 512 : int'(bus.imm);
            if (bus.br_reg) tgt = int'(bus.rs_data);
            else tgt = (int'(bus.br_pc) + 2 + 2 * simm) & 32'hFFFF;
            if (bus.br_valid) m_brc = (m_brc < CMAX) ? m_brc + 1 : CMAX;
            m_flush = 0;
            if (tk) begin
                m_pc = tgt;
                m_flush = 1;
                m_tkc = (m_tkc < CMAX) ? m_tkc + 1 : CMAX;
            end else if (bus.stall) begin
                m_pc = m_pc;
            end else if (bus.halt) begin
                m_halted = 1;
            end else begin
                m_pc = (m_pc + 2) % 65536;
            end
        end else begin
            m_flush = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("pc", 32'(bus.pc), 32'(m_pc));
        check("pc_plus", 32'(bus.pc_plus), 32'((m_pc + 2) % 65536));
        check("flush", 32'(bus.flush), 32'(m_flush));
        check("halted", 32'(bus.halted), 32'(m_halted));
        check("br_count", 32'(bus.br_count), 32'(m_brc));
        check("taken_count", 32'(bus.taken_count), 32'(m_tkc));
    endtask

    task automatic drive(input logic r, input logic st, input logic h, input logic bv, input logic breg,
                         input logic [2:0] c, input logic [8:0] im, input logic [15:0] rs,
                         input logic [15:0] bp, input logic [2:0] fl);
        rst = r; bus.stall = st; bus.halt = h; bus.br_valid = bv; bus.br_reg = breg;
        bus.cond = c; bus.imm = im; bus.rs_data = rs; bus.br_pc = bp; bus.flags = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b000);
    endtask

    initial begin
        // Reset, then free-run
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'h0, 16'h0, 3'b000);
        tick();
        check("reset_pc", 32'(bus.pc), 32'h0000);
        idle();
        for (int i = 0; i < 4; i++) tick();
        check("freerun_pc", 32'(bus.pc), 32'h0008);

        // B always with negative offset
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 9'h1FE, 16'h0, 16'h0010, 3'b000);
        tick();
        check("b_neg_pc", 32'(bus.pc), 32'h000E);
        check("b_neg_flush", 32'(bus.flush), 32'h1);
        idle();
        tick();
        check("flush_drop", 32'(bus.flush), 32'h0);

        // cond 000 with Z=1 (not taken), then Z=0 (taken)
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 9'h005, 16'h0, 16'h0040, 3'b100);
        tick();
        check("nt_taken_cnt", 32'(bus.taken_count), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 9'h005, 16'h0, 16'h0040, 3'b000);
        tick();
        check("z0_pc", 32'(bus.pc), 32'h004C);

        // BR overriding stall, then stall alone
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 9'h0, 16'hBEEF, 16'h0, 3'b000);
        tick();
        check("br_stall_pc", 32'(bus.pc), 32'hBEEF);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 9'h0, 16'h0, 16'h0, 3'b000);
        for (int i = 0; i < 3; i++) tick();
        check("stall_hold", 32'(bus.pc), 32'hBEEF);

        // Wrap from top of address space
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 9'h0, 16'hFFFE, 16'h0, 3'b000);
        tick();
        idle();
        tick();
        check("wrap_pc", 32'(bus.pc), 32'h0000);

        // HALT at 0x0020, then ignore branches while halted
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 9'h0, 16'h0020, 16'h0, 3'b000);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 9'h0, 16'h0, 16'h0, 3'b000);
        tick();
        check("halt_state", 32'(bus.halted), 32'h1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 3'd7, 9'($urandom),
                  16'($urandom), 16'($urandom), 3'($urandom));
            tick();
        end
        check("halt_frozen", 32'(bus.pc), 32'h0020);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 9'h0, 16'h0, 16'h0, 3'b000);
        tick();
        check("halt_reset_pc", 32'(bus.pc), 32'h0000);
        check("halt_reset_h", 32'(bus.halted), 32'h0);

        // Saturation after 20 taken branches
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'($urandom), 1'b0, 1'b1, 1'b1, 3'd7, 9'h0, 16'($urandom), 16'h0, 3'b000);
            tick();
        end
        check("sat_taken", 32'(bus.taken_count), 32'hF);
        check("sat_br", 32'(bus.br_count), 32'hF);

        // Random traffic
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 9'h0, 16'h0, 16'h0, 3'b000);
        tick();
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom),
                  3'($urandom), 9'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
